scan_tap_capture: RTL and testbench

Parametrised scan-chain tap for the board-level test harness. It samples the chip's scan clock and scan data on the 12 MHz board clock and keeps the last WIDTH bits seen on the chain. On each latch event it snapshots those bits into a DEPTH-entry history ring, which the buttons can step through. It replaces the fixed 8-bit last-data capture that feeds the 7-segment and LED-matrix display path.

---
 rtl/scan_tap_pkg.sv | 22 ++
 rtl/scan_tap_sync.sv | 70 +++++++
 rtl/scan_tap_capture.sv | 161 ++++++++++++++++
 tb/tb_scan_tap_capture.sv | 199 +++++++++++++++++++
 4 files changed

// File: rtl/scan_tap_pkg.sv
`default_nettype none
// +------------------------------------------------------------------+
// | scan_tap_pkg: shared types and constants for the scan-chain tap   |
// | Rev 1.0                                                           |
// +------------------------------------------------------------------+
package scan_tap_pkg;

  typedef enum logic [0:0] {
    MODE_LIVE   = 1'b0,
    MODE_BROWSE = 1'b1
  } mode_e;

  localparam int BIT_COUNT_W = 16;
  localparam int FILT_LEN    = 3;

  // Synchroniser flavours: plain, glitch-filtered, or delayed to match the filter
  localparam int SYNC_PLAIN  = 0;
  localparam int SYNC_FILTER = 1;
  localparam int SYNC_DELAY  = 2;

endpackage
`default_nettype wire

// File: rtl/scan_tap_sync.sv
`default_nettype none
// +------------------------------------------------------------------+
// | scan_tap_sync: async-input synchroniser, optional glitch filter   |
// | and rising-edge pulse. Rev 1.0                                    |
// +------------------------------------------------------------------+
module scan_tap_sync
  import scan_tap_pkg::*;
#(
  parameter int SYNC_STAGES = 2,
  parameter int MODE        = SYNC_PLAIN
) (
  input  logic clk,
  input  logic rst,
  input  logic i_async,
  output logic o_level,
  output logic o_rise
);

  localparam int WARM_LEN = SYNC_STAGES + FILT_LEN;

  logic [SYNC_STAGES-1:0] r_sync;
  logic [WARM_LEN-1:0]    r_warm;
  logic                   r_prev;
  logic                   w_synced;
  logic                   w_level;

  assign w_synced = r_sync[SYNC_STAGES-1];

  // Edges are suppressed until the chain has refilled, so a level held through reset is not an edge
  always_ff @(posedge clk) begin
    if (rst) begin
      r_sync <= '0;
      r_warm <= '0;
      r_prev <= 1'b0;
    end else begin
      r_sync <= {r_sync[SYNC_STAGES-2:0], i_async};
      r_warm <= {r_warm[WARM_LEN-2:0], 1'b1};
      r_prev <= w_level;
    end
  end

  generate
    if (MODE == SYNC_FILTER) begin : g_filter
      logic [FILT_LEN-2:0] r_hist;
      always_ff @(posedge clk) begin
        if (rst) r_hist <= '0;
        else     r_hist <= {r_hist[FILT_LEN-3:0], w_synced};
      end
      always_comb begin
        w_level = r_prev;
        if (&{w_synced, r_hist})       w_level = 1'b1;
        else if (~|{w_synced, r_hist}) w_level = 1'b0;
      end
    end else if (MODE == SYNC_DELAY) begin : g_delay
      logic [FILT_LEN-2:0] r_dly;
      always_ff @(posedge clk) begin
        if (rst) r_dly <= '0;
        else     r_dly <= {r_dly[FILT_LEN-3:0], w_synced};
      end
      assign w_level = r_dly[FILT_LEN-2];
    end else begin : g_plain
      assign w_level = w_synced;
    end
  endgenerate

  assign o_level = w_level;
  assign o_rise  = w_level & ~r_prev & r_warm[WARM_LEN-1];

endmodule
`default_nettype wire

// File: rtl/scan_tap_capture.sv
`default_nettype none
// +------------------------------------------------------------------+
// | scan_tap_capture: scan-chain tap with DEPTH-entry history ring.   |
// | Option macro: SCAN_TAP_FILTER_EN (scan clock glitch filter).      |
// | Rev 1.0                                                           |
// +------------------------------------------------------------------+
module scan_tap_capture
  import scan_tap_pkg::*;
#(
  parameter int WIDTH       = 8,
  parameter int DEPTH       = 4,
  parameter int SYNC_STAGES = 2
) (
  input  logic                       clk12MHz,
  input  logic                       rst,
  input  logic                       scan_clk_in,
  input  logic                       scan_data_out,
  input  logic                       scan_latch_en,
  input  logic                       seg_latch,
  input  logic                       hist_prev,
  input  logic                       hist_next,
  output logic [WIDTH-1:0]           view_data,
  output logic [$clog2(DEPTH)-1:0]   view_index,
  output logic                       view_valid,
  output logic                       browsing,
  output logic [BIT_COUNT_W-1:0]     bit_count,
  output logic                       overflow
);

  localparam int PTR_W  = $clog2(DEPTH);
  localparam int FILL_W = PTR_W + 1;
`ifdef SCAN_TAP_FILTER_EN
  localparam int CLK_MODE  = SYNC_FILTER;
  localparam int DATA_MODE = SYNC_DELAY;
`else
  localparam int CLK_MODE  = SYNC_PLAIN;
  localparam int DATA_MODE = SYNC_PLAIN;
`endif

  logic w_shift, w_data, w_latch_rise, w_seg_rise, w_cap;
  logic w_unused_clk_lvl, w_unused_data_rise, w_unused_latch_lvl, w_unused_seg_lvl;

  scan_tap_sync #(.SYNC_STAGES(SYNC_STAGES), .MODE(CLK_MODE)) u_sync_clk (
    .clk(clk12MHz), .rst(rst), .i_async(scan_clk_in), .o_level(w_unused_clk_lvl), .o_rise(w_shift));
  scan_tap_sync #(.SYNC_STAGES(SYNC_STAGES), .MODE(DATA_MODE)) u_sync_data (
    .clk(clk12MHz), .rst(rst), .i_async(scan_data_out), .o_level(w_data), .o_rise(w_unused_data_rise));
  scan_tap_sync #(.SYNC_STAGES(SYNC_STAGES), .MODE(SYNC_PLAIN)) u_sync_latch (
    .clk(clk12MHz), .rst(rst), .i_async(scan_latch_en), .o_level(w_unused_latch_lvl), .o_rise(w_latch_rise));
  scan_tap_sync #(.SYNC_STAGES(SYNC_STAGES), .MODE(SYNC_PLAIN)) u_sync_seg (
    .clk(clk12MHz), .rst(rst), .i_async(seg_latch), .o_level(w_unused_seg_lvl), .o_rise(w_seg_rise));

  assign w_cap = w_latch_rise | w_seg_rise;

  logic [WIDTH-1:0]       r_sr;
  logic [WIDTH-1:0]       r_mem [DEPTH];
  logic [PTR_W-1:0]       r_wr_ptr;
  logic [FILL_W-1:0]      r_fill;
  logic [BIT_COUNT_W-1:0] r_bit_count;
  logic                   r_overflow;
  mode_e                  r_mode;
  logic [PTR_W-1:0]       r_view_idx;
  logic [WIDTH-1:0]       r_view_data;
  logic                   r_view_valid;
  logic                   r_browsing;

  logic [WIDTH-1:0]  w_sr_nxt;
  logic [FILL_W-1:0] w_fill_nxt;
  logic              w_full;
  logic [PTR_W-1:0]  w_newest, w_oldest;
  logic              w_hp, w_hn;
  mode_e             w_mode_nxt;
  logic [PTR_W-1:0]  w_idx_nxt;
  logic [WIDTH-1:0]  w_view_data_nxt;

  assign w_sr_nxt   = w_shift ? {r_sr[WIDTH-2:0], w_data} : r_sr;
  assign w_full     = (r_fill == FILL_W'(DEPTH));
  assign w_fill_nxt = (w_cap && !w_full) ? r_fill + FILL_W'(1) : r_fill;
  assign w_newest   = r_wr_ptr - PTR_W'(1);
  assign w_oldest   = r_wr_ptr - r_fill[PTR_W-1:0];
  assign w_hp       = hist_prev & ~hist_next & (r_fill != '0);
  assign w_hn       = hist_next & ~hist_prev & (r_fill != '0);

  always_comb begin
    w_mode_nxt = r_mode;
    w_idx_nxt  = r_view_idx;
    case (r_mode)
      MODE_LIVE: begin
        if (w_hp && r_fill >= FILL_W'(2)) begin
          w_mode_nxt = MODE_BROWSE;
          w_idx_nxt  = w_newest - PTR_W'(1);
        end
      end
      MODE_BROWSE: begin
        if (w_hp && r_view_idx != w_oldest) begin
          w_idx_nxt = r_view_idx - PTR_W'(1);
        end else if (w_hn) begin
          w_idx_nxt = r_view_idx + PTR_W'(1);
          if (w_idx_nxt == w_newest) w_mode_nxt = MODE_LIVE;
        end
      end
      default: w_mode_nxt = MODE_LIVE;
    endcase
    // A capture into a full ring evicts the oldest slot; keep the view on the oldest survivor
    if (w_cap && w_mode_nxt == MODE_BROWSE && w_full && w_idx_nxt == w_oldest) begin
      w_idx_nxt = w_idx_nxt + PTR_W'(1);
      if (w_idx_nxt == r_wr_ptr) w_mode_nxt = MODE_LIVE;
    end
    if (w_cap && w_mode_nxt == MODE_LIVE) w_idx_nxt = r_wr_ptr;
  end

  assign w_view_data_nxt = (w_fill_nxt == '0)                ? '0       :
                           (w_cap && w_idx_nxt == r_wr_ptr) ? w_sr_nxt :
                                                              r_mem[w_idx_nxt];

  always_ff @(posedge clk12MHz) begin
    if (rst) begin
      r_sr         <= '0;
      r_wr_ptr     <= '0;
      r_fill       <= '0;
      r_bit_count  <= '0;
      r_overflow   <= 1'b0;
      r_mode       <= MODE_LIVE;
      r_view_idx   <= '0;
      r_view_data  <= '0;
      r_view_valid <= 1'b0;
      r_browsing   <= 1'b0;
    end else begin
      r_sr         <= w_sr_nxt;
      r_fill       <= w_fill_nxt;
      r_mode       <= w_mode_nxt;
      r_view_idx   <= w_idx_nxt;
      r_view_data  <= w_view_data_nxt;
      r_view_valid <= (w_fill_nxt != '0);
      r_browsing   <= (w_mode_nxt == MODE_BROWSE);
      if (w_cap) begin
        r_wr_ptr    <= r_wr_ptr + PTR_W'(1);
        r_bit_count <= BIT_COUNT_W'(w_shift);
        if (w_full) r_overflow <= 1'b1;
      end else if (w_shift && r_bit_count != '1) begin
        r_bit_count <= r_bit_count + BIT_COUNT_W'(1);
      end
    end
  end

  always_ff @(posedge clk12MHz) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) r_mem[i] <= '0;
    end else if (w_cap) begin
      r_mem[r_wr_ptr] <= w_sr_nxt;
    end
  end

  assign view_data  = r_view_data;
  assign view_index = r_view_idx;
  assign view_valid = r_view_valid;
  assign browsing   = r_browsing;
  assign bit_count  = r_bit_count;
  assign overflow   = r_overflow;

endmodule
`default_nettype wire

// File: tb/tb_scan_tap_capture.sv
`default_nettype none
// +------------------------------------------------------------------+
// | tb_scan_tap_capture: directed self-checking bench, WIDTH=8 DEPTH=4|
// | Rev 1.0                                                           |
// +------------------------------------------------------------------+
module tb_scan_tap_capture;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        scan_clk_in = 1'b0, scan_data_out = 1'b0;
  logic        scan_latch_en = 1'b0, seg_latch = 1'b0;
  logic        hist_prev = 1'b0, hist_next = 1'b0;
  logic [7:0]  view_data;
  logic [1:0]  view_index;
  logic        view_valid, browsing, overflow;
  logic [15:0] bit_count;

  int total = 0;
  int bad   = 0;

  scan_tap_capture #(.WIDTH(8), .DEPTH(4), .SYNC_STAGES(2)) dut (
    .clk12MHz(clk), .rst(rst),
    .scan_clk_in(scan_clk_in), .scan_data_out(scan_data_out),
    .scan_latch_en(scan_latch_en), .seg_latch(seg_latch),
    .hist_prev(hist_prev), .hist_next(hist_next),
    .view_data(view_data), .view_index(view_index), .view_valid(view_valid),
    .browsing(browsing), .bit_count(bit_count), .overflow(overflow));

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic shift_bit(input logic b);
    scan_data_out = b;
    @(posedge clk); #1 scan_clk_in = 1'b1;
    repeat (6) @(posedge clk); #1 scan_clk_in = 1'b0;
    repeat (6) @(posedge clk); #1;
  endtask

  task automatic shift_byte(input logic [7:0] b);
    for (int i = 7; i >= 0; i--) shift_bit(b[i]);
  endtask

  task automatic pulse_cap(input logic l, input logic s);
    @(posedge clk); #1 scan_latch_en = l; seg_latch = s;
    repeat (4) @(posedge clk); #1 scan_latch_en = 1'b0; seg_latch = 1'b0;
    repeat (6) @(posedge clk);
    @(negedge clk);
  endtask

  task automatic pulse_hist(input logic p, input logic n);
    @(posedge clk); #1 hist_prev = p; hist_next = n;
    @(posedge clk); #1 hist_prev = 1'b0; hist_next = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
  endtask

  task automatic do_reset();
    @(posedge clk); #1 rst = 1'b1;
    repeat (3) @(posedge clk); #1 rst = 1'b0;
    @(negedge clk);
  endtask

  initial begin
    do_reset();
    check("rst_data", view_data, 8'h00);
    check("rst_idx", view_index, 2'd0);
    check("rst_valid", view_valid, 1'b0);
    check("rst_browse", browsing, 1'b0);
    check("rst_bc", bit_count, 16'd0);
    check("rst_ovf", overflow, 1'b0);
    repeat (10) @(posedge clk);

    // First capture: 0xA5 via scan_latch_en
    shift_byte(8'hA5);
    @(negedge clk);
    check("a5_bc_pre", bit_count, 16'd8);
    pulse_cap(1'b1, 1'b0);
    check("a5_data", view_data, 8'hA5);
    check("a5_idx", view_index, 2'd0);
    check("a5_valid", view_valid, 1'b1);
    check("a5_bc", bit_count, 16'd0);
    check("a5_browse", browsing, 1'b0);

    // Fill and overflow the ring with 0x01..0x05
    do_reset();
    repeat (10) @(posedge clk);
    for (int k = 1; k <= 5; k++) begin
      shift_byte(8'(k));
      pulse_cap(1'b1, 1'b0);
      if (k == 4) check("ovf_before", overflow, 1'b0);
    end
    check("full_data", view_data, 8'h05);
    check("full_idx", view_index, 2'd0);
    check("full_ovf", overflow, 1'b1);

    pulse_hist(1'b1, 1'b0);
    check("hp1_data", view_data, 8'h04);
    check("hp1_idx", view_index, 2'd3);
    check("hp1_browse", browsing, 1'b1);
    pulse_hist(1'b1, 1'b1);
    check("both_data", view_data, 8'h04);
    pulse_hist(1'b1, 1'b0);
    check("hp2_data", view_data, 8'h03);
    pulse_hist(1'b1, 1'b0);
    check("hp3_data", view_data, 8'h02);
    check("hp3_idx", view_index, 2'd1);
    pulse_hist(1'b1, 1'b0);
    check("hp4_data", view_data, 8'h02);
    pulse_hist(1'b0, 1'b1);
    check("hn1_data", view_data, 8'h03);
    pulse_hist(1'b0, 1'b1);
    check("hn2_data", view_data, 8'h04);
    pulse_hist(1'b0, 1'b1);
    check("hn3_data", view_data, 8'h05);
    check("hn3_browse", browsing, 1'b0);
    check("hn3_idx", view_index, 2'd0);
    pulse_hist(1'b0, 1'b1);
    check("live_hn_data", view_data, 8'h05);
    check("live_hn_browse", browsing, 1'b0);

    // Browse at the oldest entry while full, then capture 0x06
    for (int k = 0; k < 3; k++) pulse_hist(1'b1, 1'b0);
    check("oldest_data", view_data, 8'h02);
    shift_byte(8'h06);
    pulse_cap(1'b1, 1'b0);
    check("evict_data", view_data, 8'h03);
    check("evict_idx", view_index, 2'd2);
    check("evict_browse", browsing, 1'b1);
    pulse_hist(1'b0, 1'b1);
    check("ev_hn1_data", view_data, 8'h04);
    pulse_hist(1'b0, 1'b1);
    check("ev_hn2_data", view_data, 8'h05);
    check("ev_hn2_browse", browsing, 1'b1);
    pulse_hist(1'b0, 1'b1);
    check("ev_hn3_data", view_data, 8'h06);
    check("ev_hn3_browse", browsing, 1'b0);

    // Reset mid-shift, then 0x3C via seg_latch
    for (int k = 0; k < 5; k++) shift_bit(1'b1);
    @(negedge clk);
    check("mid_bc", bit_count, 16'd5);
    do_reset();
    check("rst2_data", view_data, 8'h00);
    check("rst2_bc", bit_count, 16'd0);
    check("rst2_ovf", overflow, 1'b0);
    check("rst2_valid", view_valid, 1'b0);
    repeat (10) @(posedge clk);
    pulse_hist(1'b1, 1'b0);
    check("empty_hp_browse", browsing, 1'b0);
    check("empty_hp_valid", view_valid, 1'b0);
    shift_byte(8'h3C);
    pulse_cap(1'b0, 1'b1);
    check("3c_data", view_data, 8'h3C);
    check("3c_bc", bit_count, 16'd0);
    check("3c_idx", view_index, 2'd0);
    pulse_cap(1'b1, 1'b1);
    check("coinc_idx", view_index, 2'd1);
    check("coinc_data", view_data, 8'h3C);

    scan_data_out = 1'b1;
`ifdef SCAN_TAP_FILTER_EN
    @(posedge clk); #1 scan_clk_in = 1'b1;
    @(posedge clk); #1 scan_clk_in = 1'b0;
    repeat (10) @(posedge clk);
    @(negedge clk);
    check("glitch_bc", bit_count, 16'd0);
    @(posedge clk); #1 scan_clk_in = 1'b1;
    repeat (6) @(posedge clk); #1 scan_clk_in = 1'b0;
`else
    @(posedge clk); #1 scan_clk_in = 1'b1;
    repeat (3) @(posedge clk); #1 scan_clk_in = 1'b0;
`endif
    repeat (10) @(posedge clk);
    @(negedge clk);
    check("pulse_bc", bit_count, 16'd1);
    pulse_cap(1'b1, 1'b0);
    check("pulse_data", view_data, 8'h79);
    check("pulse_idx", view_index, 2'd2);
    check("pulse_bc0", bit_count, 16'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
